// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - LED pattern animator (static/rotate/bounce/blink) fed by the slave register bank
// Optional PWM dimming from slv_reg3[7:0] is compiled in when LED_PATTERN_PWM_EN is defined.
module led_pattern_engine #(
  parameter int LED_WIDTH          = 8,
  parameter int C_S_AXI_DATA_WIDTH = 32
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg0,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg1,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg2,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] slv_reg3,
  input  logic [3:0]                    reg_wr,
  output logic [LED_WIDTH-1:0]          led,
  output logic                          step_tick,
  output logic                          busy
);
  localparam int DW = C_S_AXI_DATA_WIDTH;

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t               state;
  logic [LED_WIDTH-1:0] shadow;
  logic [DW-1:0]        per_cnt;
  logic                 dir;     // 0 = moving left, 1 = moving right
  logic                 phase;

  logic                 enable;
  logic                 restart;
  logic [1:0]           mode;
  logic [DW-1:0]        limit;
  logic                 step;
  logic                 reload;
  logic                 gate;
  logic [LED_WIDTH-1:0] load_frame;
  logic [LED_WIDTH-1:0] next_shadow;
  logic                 next_dir;
  logic                 next_phase;
  logic [LED_WIDTH-1:0] frame;
  logic                 unused_bits;

  assign enable     = slv_reg0[0];
  assign mode       = slv_reg0[2:1];
  assign restart    = slv_reg0[3];
  assign limit      = (slv_reg2 == '0) ? '0 : slv_reg2 - DW'(1);
  assign step       = (per_cnt >= limit);
  assign reload     = reg_wr[1] | (reg_wr[0] & restart);
  assign load_frame = slv_reg1[LED_WIDTH-1:0];
  assign unused_bits = ^{slv_reg0, slv_reg1, slv_reg3, reg_wr};

  always_comb begin
    next_shadow = shadow;
    next_dir    = dir;
    next_phase  = phase;
    if (step) begin
      case (mode)
        2'b01: next_shadow = {shadow[LED_WIDTH-2:0], shadow[LED_WIDTH-1]};
        2'b10: begin
          // An all-zero shadow never hits an end bit, so dir stays put.
          if (!dir) begin
            if (shadow[LED_WIDTH-1]) begin
              next_dir    = 1'b1;
              next_shadow = shadow >> 1;
            end else begin
              next_shadow = shadow << 1;
            end
          end else begin
            if (shadow[0]) begin
              next_dir    = 1'b0;
              next_shadow = shadow << 1;
            end else begin
              next_shadow = shadow >> 1;
            end
          end
        end
        2'b11:   next_phase = ~phase;
        default: next_shadow = shadow;
      endcase
    end
    frame = (mode == 2'b11 && next_phase) ? '0 : next_shadow;
  end

`ifdef LED_PATTERN_PWM_EN
  logic [7:0] pwm_cnt;

  assign gate = (slv_reg3[7:0] == 8'hFF) || (pwm_cnt < slv_reg3[7:0]);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      pwm_cnt <= 8'd0;
    end else if (state == RUN) begin
      pwm_cnt <= pwm_cnt + 8'd1;
    end else if (state == IDLE) begin
      pwm_cnt <= 8'd0;
    end
  end
`else
  assign gate = 1'b1;
`endif

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state     <= IDLE;
      shadow    <= '0;
      per_cnt   <= '0;
      dir       <= 1'b0;
      phase     <= 1'b0;
      led       <= '0;
      step_tick <= 1'b0;
      busy      <= 1'b0;
    end else begin
      step_tick <= 1'b0;
      case (state)
        IDLE: begin
          led  <= '0;
          busy <= 1'b0;
          if (enable) begin
            state <= LOAD;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          shadow  <= load_frame;
          per_cnt <= '0;
          dir     <= 1'b0;
          phase   <= 1'b0;
          led     <= load_frame & {LED_WIDTH{gate}};
          state   <= RUN;
        end
        RUN: begin
          if (!enable) begin
            state   <= IDLE;
            led     <= '0;
            busy    <= 1'b0;
            per_cnt <= '0;
          end else begin
            step_tick <= step;
            // A reload discards any coincident step; led holds through LOAD.
            if (reload) begin
              state <= LOAD;
            end else begin
              per_cnt <= step ? '0 : per_cnt + DW'(1);
              shadow  <= next_shadow;
              dir     <= next_dir;
              phase   <= next_phase;
              led     <= frame & {LED_WIDTH{gate}};
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed vector bench for led_pattern_engine (PWM checks when LED_PATTERN_PWM_EN is defined)
module tb_led_pattern_engine;
  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [31:0] slv_reg0, slv_reg1, slv_reg2, slv_reg3;
  logic [3:0]  reg_wr;
  logic [7:0]  led;
  logic        step_tick;
  logic        busy;

  int total = 0;
  int bad   = 0;

  led_pattern_engine #(.LED_WIDTH(8), .C_S_AXI_DATA_WIDTH(32)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .slv_reg0(slv_reg0), .slv_reg1(slv_reg1), .slv_reg2(slv_reg2), .slv_reg3(slv_reg3),
    .reg_wr(reg_wr), .led(led), .step_tick(step_tick), .busy(busy)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic        en;
    logic [1:0]  mode;
    logic        rst;
    logic [7:0]  pat;
    logic [31:0] per;
    logic [3:0]  wr;
    logic [7:0]  e_led;
    logic        e_tick;
    logic        e_busy;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic en, logic [1:0] mode, logic rst, logic [7:0] pat, logic [31:0] per,
                              logic [3:0] wr, logic [7:0] e_led, logic e_tick, logic e_busy);
    vec_t v;
    v.en = en; v.mode = mode; v.rst = rst; v.pat = pat; v.per = per; v.wr = wr;
    v.e_led = e_led; v.e_tick = e_tick; v.e_busy = e_busy;
    vecs.push_back(v);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge ACLK);
    #1;
  endtask

  // Each row: drive inputs, clock once, compare {led, step_tick, busy}.
  task automatic run_vecs(string name);
    for (int i = 0; i < vecs.size(); i++) begin
      slv_reg0 = {28'd0, vecs[i].rst, vecs[i].mode, vecs[i].en};
      slv_reg1 = {24'd0, vecs[i].pat};
      slv_reg2 = vecs[i].per;
      reg_wr   = vecs[i].wr;
      cyc();
      check($sformatf("%s[%0d] led/tick/busy", name, i), 32'({led, step_tick, busy}),
            32'({vecs[i].e_led, vecs[i].e_tick, vecs[i].e_busy}));
    end
    reg_wr = 4'd0;
    vecs.delete();
  endtask

  initial begin
    int on;
    int other;
    ARESETN = 1'b0;
    slv_reg0 = '0; slv_reg1 = '0; slv_reg2 = '0; slv_reg3 = '0; reg_wr = '0;
    repeat (2) @(posedge ACLK);
    #1;
    check("reset_state", 32'({led, step_tick, busy}), 32'd0);
    ARESETN = 1'b1;

    // static 0xA5, P=4, plus reg_wr[0] with and without restart
    add(0, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'h00, 0, 0);
    add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 0, 1);
    add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 1, 1);
    for (int i = 0; i < 3; i++) add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 0, 1);
    add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 1, 1);
    add(1, 2'b00, 0, 8'hA5, 4, 4'b0001, 8'hA5, 0, 1);
    add(1, 2'b00, 1, 8'hA5, 4, 4'b0001, 8'hA5, 0, 1);
    add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 0, 1);
    add(1, 2'b00, 0, 8'hA5, 4, 4'b0000, 8'hA5, 1, 1);
    run_vecs("static");

    #2;
    ARESETN = 1'b0;
    #1;
    check("async_reset_mid_run", 32'({led, step_tick, busy}), 32'd0);
    slv_reg0 = '0;
    cyc();
    ARESETN = 1'b1;
    cyc();
    check("idle_after_reset", 32'({led, step_tick, busy}), 32'd0);

    // rotate 0x81, P=2
    add(0, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h00, 0, 0);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h81, 0, 1);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h81, 0, 1);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h03, 1, 1);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h03, 0, 1);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h06, 1, 1);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h06, 0, 1);
    add(1, 2'b01, 0, 8'h81, 2, 4'b0000, 8'h0C, 1, 1);
    run_vecs("rotate");

    // bounce 0x40, P=1, then all-zero pattern
    add(0, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h00, 0, 0);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h40, 0, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h80, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h40, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h20, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h10, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h08, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h04, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h02, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h01, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h02, 1, 1);
    add(1, 2'b10, 0, 8'h40, 1, 4'b0000, 8'h04, 1, 1);
    add(0, 2'b10, 0, 8'h00, 1, 4'b0000, 8'h00, 0, 0);
    add(1, 2'b10, 0, 8'h00, 1, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b10, 0, 8'h00, 1, 4'b0000, 8'h00, 0, 1);
    for (int i = 0; i < 4; i++) add(1, 2'b10, 0, 8'h00, 1, 4'b0000, 8'h00, 1, 1);
    run_vecs("bounce");

    // blink 0x0F, P=3, reload with 0xF0 on a step cycle
    add(0, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h00, 0, 0);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h0F, 0, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h0F, 0, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h0F, 0, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h00, 1, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h0F, 1, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h0F, 0, 1);
    add(1, 2'b11, 0, 8'h0F, 3, 4'b0000, 8'h0F, 0, 1);
    add(1, 2'b11, 0, 8'hF0, 3, 4'b0010, 8'h0F, 1, 1);
    add(1, 2'b11, 0, 8'hF0, 3, 4'b0000, 8'hF0, 0, 1);
    add(1, 2'b11, 0, 8'hF0, 3, 4'b0000, 8'hF0, 0, 1);
    add(1, 2'b11, 0, 8'hF0, 3, 4'b0000, 8'hF0, 0, 1);
    add(1, 2'b11, 0, 8'hF0, 3, 4'b0000, 8'h00, 1, 1);
    run_vecs("blink_reload");

    // P=0 behaves as P=1
    add(0, 2'b00, 0, 8'h3C, 0, 4'b0000, 8'h00, 0, 0);
    add(1, 2'b00, 0, 8'h3C, 0, 4'b0000, 8'h00, 0, 1);
    add(1, 2'b00, 0, 8'h3C, 0, 4'b0000, 8'h3C, 0, 1);
    for (int i = 0; i < 3; i++) add(1, 2'b00, 0, 8'h3C, 0, 4'b0000, 8'h3C, 1, 1);
    run_vecs("period0");

    // period shrinks from 100 to 5 while per_cnt=50
    slv_reg0 = 32'd0; slv_reg1 = 32'h55; slv_reg2 = 32'd100;
    cyc();
    slv_reg0 = 32'd1;
    cyc();
    cyc();
    for (int k = 1; k <= 57; k++) begin
      cyc();
      check($sformatf("period_change_tick[%0d]", k), 32'(step_tick), 32'((k == 51) || (k == 56)));
      if (k == 50) slv_reg2 = 32'd5;
    end

`ifdef LED_PATTERN_PWM_EN
    slv_reg0 = 32'd0; slv_reg1 = 32'hFF; slv_reg2 = 32'd1000; slv_reg3 = 32'h40;
    cyc();
    slv_reg0 = 32'd1;
    cyc();
    cyc();
    on = 0; other = 0;
    for (int k = 0; k < 256; k++) begin
      cyc();
      if (led == 8'hFF) on++; else if (led != 8'h00) other++;
    end
    check("pwm_40_on_cycles", 32'(on), 32'd64);
    check("pwm_40_partial", 32'(other), 32'd0);
    slv_reg3 = 32'h00;
    cyc();
    on = 0;
    for (int k = 0; k < 256; k++) begin
      cyc();
      if (led != 8'h00) on++;
    end
    check("pwm_00_on_cycles", 32'(on), 32'd0);
    slv_reg3 = 32'hFF;
    cyc();
    on = 0;
    for (int k = 0; k < 256; k++) begin
      cyc();
      if (led == 8'hFF) on++;
    end
    check("pwm_ff_on_cycles", 32'(on), 32'd256);
`else
    slv_reg0 = 32'd0; slv_reg1 = 32'hA5; slv_reg2 = 32'd1000; slv_reg3 = 32'h00;
    cyc();
    slv_reg0 = 32'd1;
    cyc();
    cyc();
    on = 0;
    for (int k = 0; k < 20; k++) begin
      cyc();
      if (led == 8'hA5) on++;
    end
    check("brightness_ignored", 32'(on), 32'd20);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
